// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder computing a + b + cin over WIDTH bits
// DIGIT bits per clock through one carry register, with start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCYC = WIDTH / DIGIT;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_carry;
  logic             msb_carry_in;

  always_comb begin
    {dig_carry, dig_sum} = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                         + {{DIGIT{1'b0}}, carry_q};
    // Carry into the digit's top bit recovered from that bit's sum and operands.
    msb_carry_in = dig_sum[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
    // New digit enters at the MSB end; after NCYC shifts the LSB digit sits at bit 0.
    acc_next = (acc >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      carry_q  <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc     <= acc_next;
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          carry_q <= dig_carry;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum      <= acc_next;
            cout     <= dig_carry;
            overflow <= msb_carry_in ^ dig_carry;
            busy     <= 1'b0;
            done     <= 1'b1;
            cnt      <= '0;
            state    <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed bench for serial_adder
// Checks W=8 (D=1,4) and exhaustive W=4 (D=1,2,4) against an arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start81, start84, start4;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [3:0] a4, b4;
  logic       cin4;

  logic       busy81, done81, cout81, ov81;
  logic [7:0] sum81;
  logic       busy84, done84, cout84, ov84;
  logic [7:0] sum84;
  logic       busy41, done41, cout41, ov41;
  logic [3:0] sum41;
  logic       busy42, done42, cout42, ov42;
  logic [3:0] sum42;
  logic       busy44, done44, cout44, ov44;
  logic [3:0] sum44;

  serial_adder #(.WIDTH(8), .DIGIT(1)) d81 (.clk(clk), .rst_n(rst_n), .start(start81), .a(a8), .b(b8),
    .cin(cin8), .busy(busy81), .done(done81), .sum(sum81), .cout(cout81), .overflow(ov81));
  serial_adder #(.WIDTH(8), .DIGIT(4)) d84 (.clk(clk), .rst_n(rst_n), .start(start84), .a(a8), .b(b8),
    .cin(cin8), .busy(busy84), .done(done84), .sum(sum84), .cout(cout84), .overflow(ov84));
  serial_adder #(.WIDTH(4), .DIGIT(1)) d41 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy41), .done(done41), .sum(sum41), .cout(cout41), .overflow(ov41));
  serial_adder #(.WIDTH(4), .DIGIT(2)) d42 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy42), .done(done42), .sum(sum42), .cout(cout42), .overflow(ov42));
  serial_adder #(.WIDTH(4), .DIGIT(4)) d44 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy44), .done(done44), .sum(sum44), .cout(cout44), .overflow(ov44));

  logic [2:0] done4v;
  logic [5:0] res4 [3];
  assign done4v  = {done44, done42, done41};
  assign res4[0] = {ov41, cout41, sum41};
  assign res4[1] = {ov42, cout42, sum42};
  assign res4[2] = {ov44, cout44, sum44};

  int total = 0;
  int bad   = 0;

  int lat81, lat84, bz81, bz84, extra81, extra84;
  logic [9:0] r81, r84;

  // Reference: plain integer addition, signed overflow when like-signed operands give an unlike-signed sum.
  function automatic int unsigned ref_add(input int w, input int unsigned x, input int unsigned y,
                                          input int unsigned c);
    int unsigned s, m, res, co, sx, sy, ss, ov;
    s   = x + y + c;
    m   = (32'd1 << w) - 1;
    res = s & m;
    co  = (s >> w) & 1;
    sx  = (x >> (w - 1)) & 1;
    sy  = (y >> (w - 1)) & 1;
    ss  = (res >> (w - 1)) & 1;
    ov  = ((sx == sy) && (ss != sx)) ? 1 : 0;
    return (ov << (w + 1)) | (co << w) | res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation on both W=8 instances and watches 14 edges; edge k=1 samples start.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
    a8 = ta; b8 = tb; cin8 = tc;
    start81 = 1'b1; start84 = 1'b1;
    lat81 = 0; lat84 = 0; bz81 = 0; bz84 = 0; extra81 = 0; extra84 = 0;
    r81 = '0; r84 = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      start81 = 1'b0; start84 = 1'b0;
      if (busy81) bz81++;
      if (busy84) bz84++;
      if (done81) begin
        if (lat81 == 0) begin lat81 = k; r81 = {ov81, cout81, sum81}; end
        else extra81++;
      end
      if (done84) begin
        if (lat84 == 0) begin lat84 = k; r84 = {ov84, cout84, sum84}; end
        else extra84++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start81 = 0; start84 = 0; start4 = 0;
    a8 = '0; b8 = '0; cin8 = 0; a4 = '0; b4 = '0; cin4 = 0;
    tick(); tick();
    total++; if ({busy81, done81, sum81, cout81, ov81} !== 11'd0) begin bad++;
      $display("FAIL reset_d81 got=%h want=0", {busy81, done81, sum81, cout81, ov81}); end
    total++; if ({busy84, done84, sum84, cout84, ov84} !== 11'd0) begin bad++;
      $display("FAIL reset_d84 got=%h want=0", {busy84, done84, sum84, cout84, ov84}); end
    total++; if ({busy41, done41, sum41, cout41, ov41, busy42, done42, sum42, cout42, ov42,
                  busy44, done44, sum44, cout44, ov44} !== 24'd0) begin bad++;
      $display("FAIL reset_w4 got nonzero outputs"); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_carry_chain();
    run8(8'hFF, 8'h01, 1'b0);
    total++; if (r81 !== {1'b0, 1'b1, 8'h00}) begin bad++;
      $display("FAIL carry_chain_result got=%h want=%h", r81, {1'b0, 1'b1, 8'h00}); end
    total++; if (lat81 != 9) begin bad++;
      $display("FAIL carry_chain_latency got=%0d want=9", lat81); end
    total++; if (extra81 != 0) begin bad++;
      $display("FAIL carry_chain_single_done got=%0d extra pulses want=0", extra81); end
  endtask

  task automatic test_overflow();
    run8(8'h7F, 8'h01, 1'b0);
    total++; if (r81 !== {1'b1, 1'b0, 8'h80}) begin bad++;
      $display("FAIL ovf_pos got=%h want=%h", r81, {1'b1, 1'b0, 8'h80}); end
    run8(8'h80, 8'h80, 1'b0);
    total++; if (r81 !== {1'b1, 1'b1, 8'h00}) begin bad++;
      $display("FAIL ovf_neg got=%h want=%h", r81, {1'b1, 1'b1, 8'h00}); end
    total++; if (r84 !== {1'b1, 1'b1, 8'h00}) begin bad++;
      $display("FAIL ovf_neg_d4 got=%h want=%h", r84, {1'b1, 1'b1, 8'h00}); end
  endtask

  task automatic test_digit4();
    run8(8'h0F, 8'h00, 1'b1);
    total++; if (r84 !== {1'b0, 1'b0, 8'h10}) begin bad++;
      $display("FAIL digit4_result got=%h want=%h", r84, {1'b0, 1'b0, 8'h10}); end
    total++; if (lat84 != 3) begin bad++;
      $display("FAIL digit4_latency got=%0d want=3", lat84); end
    total++; if (bz84 != 2) begin bad++;
      $display("FAIL digit4_busy_cycles got=%0d want=2", bz84); end
    total++; if (bz81 != 8) begin bad++;
      $display("FAIL digit1_busy_cycles got=%0d want=8", bz81); end
  endtask

  task automatic test_ignore_start();
    int lat, pulses;
    logic [9:0] r;
    lat = 0; pulses = 0; r = '0;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start81 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      start81 = 1'b0;
      if (k == 4) begin a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start81 = 1'b1; end
      if (done81) begin pulses++; if (lat == 0) begin lat = k; r = {ov81, cout81, sum81}; end end
    end
    total++; if (r !== 10'(ref_add(8, 32'h12, 32'h34, 0))) begin bad++;
      $display("FAIL ignore_start_result got=%h want=%h", r, 10'(ref_add(8, 32'h12, 32'h34, 0))); end
    total++; if (lat != 9 || pulses != 1) begin bad++;
      $display("FAIL ignore_start_timing got lat=%0d pulses=%0d want lat=9 pulses=1", lat, pulses); end
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    logic [9:0] ra, rb;
    k1 = 0; k2 = 0; ra = '0; rb = '0;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start81 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      start81 = 1'b0;
      if (done81) begin
        if (k1 == 0) begin
          k1 = k; ra = {ov81, cout81, sum81};
          a8 = 8'h0F; b8 = 8'hF1; cin8 = 1'b1; start81 = 1'b1;
        end else if (k2 == 0) begin
          k2 = k; rb = {ov81, cout81, sum81};
        end
      end
    end
    total++; if (ra !== 10'(ref_add(8, 32'h10, 32'h20, 0))) begin bad++;
      $display("FAIL b2b_first got=%h want=%h", ra, 10'(ref_add(8, 32'h10, 32'h20, 0))); end
    total++; if (rb !== {1'b0, 1'b1, 8'h01}) begin bad++;
      $display("FAIL b2b_second got=%h want=%h", rb, {1'b0, 1'b1, 8'h01}); end
    total++; if (k1 != 9 || k2 - k1 != 9) begin bad++;
      $display("FAIL b2b_spacing got k1=%0d gap=%0d want k1=9 gap=9", k1, k2 - k1); end
  endtask

  task automatic test_reset_midrun();
    int pulses;
    run8(8'h12, 8'h34, 1'b0);
    total++; if (r81 !== {1'b0, 1'b0, 8'h46}) begin bad++;
      $display("FAIL midrst_pre got=%h want=%h", r81, {1'b0, 1'b0, 8'h46}); end
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1; start81 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start81 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total++; if ({busy81, done81, sum81, cout81, ov81} !== 11'd0) begin bad++;
      $display("FAIL midrst_clear got=%h want=0", {busy81, done81, sum81, cout81, ov81}); end
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done81) pulses++;
    end
    total++; if (pulses != 0) begin bad++;
      $display("FAIL midrst_no_done got=%0d pulses want=0", pulses); end
    run8(8'h55, 8'h22, 1'b0);
    total++; if (r81 !== {1'b0, 1'b0, 8'h77} || lat81 != 9) begin bad++;
      $display("FAIL midrst_after got=%h lat=%0d want=%h lat=9", r81, lat81, {1'b0, 1'b0, 8'h77}); end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    logic rc;
    logic [9:0] exp_r;
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp_r = 10'(ref_add(8, 32'(ra), 32'(rb), 32'(rc)));
      run8(ra, rb, rc);
      total++; if (r81 !== exp_r || lat81 != 9 || extra81 != 0) begin bad++;
        $display("FAIL rand_d1 a=%h b=%h c=%0d got=%h lat=%0d want=%h lat=9", ra, rb, rc, r81, lat81, exp_r); end
      total++; if (r84 !== exp_r || lat84 != 3 || extra84 != 0) begin bad++;
        $display("FAIL rand_d4 a=%h b=%h c=%0d got=%h lat=%0d want=%h lat=3", ra, rb, rc, r84, lat84, exp_r); end
    end
  endtask

  task automatic test_exhaustive_w4();
    int lat [3];
    int pulses [3];
    logic [5:0] got [3];
    logic [5:0] exp_r;
    int exp_lat [3] = '{5, 3, 2};
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); start4 = 1'b1;
          exp_r = 6'(ref_add(4, x, y, c));
          for (int i = 0; i < 3; i++) begin lat[i] = 0; pulses[i] = 0; got[i] = '0; end
          for (int k = 1; k <= 6; k++) begin
            tick();
            start4 = 1'b0;
            for (int i = 0; i < 3; i++)
              if (done4v[i]) begin
                pulses[i]++;
                if (lat[i] == 0) begin lat[i] = k; got[i] = res4[i]; end
              end
          end
          for (int i = 0; i < 3; i++) begin
            total++;
            if (got[i] !== exp_r || lat[i] != exp_lat[i] || pulses[i] != 1) begin bad++;
              $display("FAIL w4_inst%0d a=%0d b=%0d c=%0d got=%h lat=%0d n=%0d want=%h lat=%0d",
                       i, x, y, c, got[i], lat[i], pulses[i], exp_r, exp_lat[i]);
            end
          end
        end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_digit4();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    test_exhaustive_w4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
